// File: rtl/fpu_operand_feeder.sv
// rtl/fpu_operand_feeder.sv - byte-stream operand assembler and result capture stage for the fpu adder
// Optional macro FEEDER_OVERRUN_EN adds the sticky overrun_out flag for bytes dropped during HOLD/PRESENT.
module fpu_operand_feeder #(
    parameter int HOLD_CYCLES    = 10,
    parameter bit BYTE_MSB_FIRST = 1'b1
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] op_A_out,
    output logic [31:0] op_B_out,
    input  logic [31:0] fpu_data_in,
    input  logic [3:0]  fpu_status_in,
    output logic [31:0] result_out,
    output logic [3:0]  status_out,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        busy
`ifdef FEEDER_OVERRUN_EN
    ,
    output logic        overrun_out
`endif
);

    typedef enum logic [1:0] {
        S_LOAD_A  = 2'd0,
        S_LOAD_B  = 2'd1,
        S_HOLD    = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_hold_cnt;
    logic [31:0] r_shadow_a;
    logic [31:0] r_shadow_b;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_result;
    logic [3:0]  r_status;
    logic        r_result_valid;
    logic        w_byte_ready;
    logic        w_busy;
    logic        w_xfer;
    logic        w_last_byte;
    logic        w_hold_done;
    logic [31:0] w_a_next;
    logic [31:0] w_b_next;

    // Places byte number idx (0 = first received) into its lane of the operand.
    function automatic logic [31:0] place_byte(input logic [31:0] cur, input logic [1:0] idx,
                                               input logic [7:0] b);
        logic [31:0] r;
        logic [1:0]  slot;
        r    = cur;
        slot = BYTE_MSB_FIRST ? ~idx : idx;
        case (slot)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    assign w_xfer      = byte_valid && w_byte_ready;
    assign w_last_byte = w_xfer && (r_byte_cnt == 2'd3);
    assign w_hold_done = (r_state == S_HOLD) && (r_hold_cnt == HOLD_LAST);
    assign w_a_next    = place_byte(r_shadow_a, r_byte_cnt, byte_in);
    assign w_b_next    = place_byte(r_shadow_b, r_byte_cnt, byte_in);

    always_comb begin
        w_next       = r_state;
        w_byte_ready = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_LOAD_A: begin
                w_byte_ready = 1'b1;
                if (w_last_byte) w_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                w_byte_ready = 1'b1;
                if (w_last_byte) w_next = S_HOLD;
            end
            S_HOLD: begin
                w_busy = 1'b1;
                if (w_hold_done) w_next = S_PRESENT;
            end
            S_PRESENT: begin
                w_busy = 1'b1;
                if (result_ready) w_next = S_LOAD_A;
            end
            default: w_next = S_LOAD_A;
        endcase
    end

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            r_state        <= S_LOAD_A;
            r_byte_cnt     <= 2'd0;
            r_hold_cnt     <= 8'd0;
            r_shadow_a     <= 32'd0;
            r_shadow_b     <= 32'd0;
            r_op_a         <= 32'd0;
            r_op_b         <= 32'd0;
            r_result       <= 32'd0;
            r_status       <= 4'd0;
            r_result_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            // The 2-bit counter wraps to 0 on the 4th transfer, ready for the next operand.
            if (w_xfer) r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_xfer && r_state == S_LOAD_A) r_shadow_a <= w_a_next;
            if (w_xfer && r_state == S_LOAD_B) r_shadow_b <= w_b_next;
            // Both operands are published together so the fpu never sees a partial load.
            if (w_last_byte && r_state == S_LOAD_B) begin
                r_op_a     <= r_shadow_a;
                r_op_b     <= w_b_next;
                r_hold_cnt <= 8'd0;
            end
            if (r_state == S_HOLD) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
                if (w_hold_done) begin
                    r_result       <= fpu_data_in;
                    r_status       <= fpu_status_in;
                    r_result_valid <= 1'b1;
                end
            end
            if (r_state == S_PRESENT && result_ready) r_result_valid <= 1'b0;
        end
    end

`ifdef FEEDER_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (byte_valid && !w_byte_ready) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun_out = r_overrun;
`endif

    assign byte_ready   = w_byte_ready;
    assign busy         = w_busy;
    assign op_A_out     = r_op_a;
    assign op_B_out     = r_op_b;
    assign result_out   = r_result;
    assign status_out   = r_status;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_fpu_operand_feeder.sv
// tb/tb_fpu_operand_feeder.sv - table-driven bench for fpu_operand_feeder (MSB-first and LSB-first instances)
module tb_fpu_operand_feeder;

    localparam int HOLD = 10;

    logic        clock100KHz;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        result_ready;
    logic [31:0] fpu_data_in;
    logic [3:0]  fpu_status_in;

    logic        byte_ready0, byte_ready1;
    logic [31:0] op_a0, op_b0, op_a1, op_b1;
    logic [31:0] result0, result1;
    logic [3:0]  status0, status1;
    logic        rvalid0, rvalid1;
    logic        busy0, busy1;
`ifdef FEEDER_OVERRUN_EN
    logic        ovr0, ovr1;
`endif

    fpu_operand_feeder #(.HOLD_CYCLES(HOLD), .BYTE_MSB_FIRST(1'b1)) dut0 (
        .clock100KHz(clock100KHz), .reset(reset),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready0),
        .op_A_out(op_a0), .op_B_out(op_b0),
        .fpu_data_in(fpu_data_in), .fpu_status_in(fpu_status_in),
        .result_out(result0), .status_out(status0), .result_valid(rvalid0),
        .result_ready(result_ready), .busy(busy0)
`ifdef FEEDER_OVERRUN_EN
        , .overrun_out(ovr0)
`endif
    );

    fpu_operand_feeder #(.HOLD_CYCLES(HOLD), .BYTE_MSB_FIRST(1'b0)) dut1 (
        .clock100KHz(clock100KHz), .reset(reset),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready1),
        .op_A_out(op_a1), .op_B_out(op_b1),
        .fpu_data_in(fpu_data_in), .fpu_status_in(fpu_status_in),
        .result_out(result1), .status_out(status1), .result_valid(rvalid1),
        .result_ready(result_ready), .busy(busy1)
`ifdef FEEDER_OVERRUN_EN
        , .overrun_out(ovr1)
`endif
    );

    typedef struct {
        logic [63:0] bytes;
        bit          gap;
        bit          stray;
        int          wait_cycles;
        logic [31:0] fpu_d;
        logic [3:0]  fpu_s;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    int   n_checks;
    int   n_fail;
    logic [31:0] m_a0, m_b0, m_a1, m_b1;
    logic m_ovr;
    vec_t vecs[4];
    vec_t post_reset_vec;

    initial begin
        clock100KHz = 1'b0;
        forever #5 clock100KHz = ~clock100KHz;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock100KHz);
        #1;
    endtask

    task automatic chk_ops();
        chk("op_a_msb", op_a0, m_a0);
        chk("op_b_msb", op_b0, m_b0);
        chk("op_a_lsb", op_a1, m_a1);
        chk("op_b_lsb", op_b1, m_b1);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        fpu_data_in   = v.fpu_d;
        fpu_status_in = v.fpu_s;
        for (int i = 0; i < 8; i++) begin
            byte_in    = v.bytes[63-8*i -: 8];
            byte_valid = 1'b1;
            chk("byte_ready_load", {31'd0, byte_ready0}, 32'd1);
            tick();
            byte_valid = 1'b0;
            if (i < 7) begin
                chk_ops();
                if (v.gap) begin
                    tick();
                    chk_ops();
                end
            end
        end
        m_a0 = v.exp_a;
        m_b0 = v.exp_b;
        m_a1 = bswap(v.exp_a);
        m_b1 = bswap(v.exp_b);
        chk_ops();
        chk("busy_hold", {31'd0, busy0}, 32'd1);
        chk("byte_ready_hold", {31'd0, byte_ready0}, 32'd0);

        byte_valid = v.stray;
        byte_in    = 8'hAA;
        n = 0;
        while (!rvalid0 && n < 40) begin
            tick();
            n++;
            chk("byte_ready_busy", {31'd0, byte_ready0}, 32'd0);
        end
        chk("latency", 32'(n), 32'(HOLD));
        chk("result", result0, v.fpu_d);
        chk("status", {28'd0, status0}, {28'd0, v.fpu_s});
        chk("result_valid_lsb", {31'd0, rvalid1}, 32'd1);
        chk("result_lsb", result1, v.fpu_d);

        fpu_data_in   = ~v.fpu_d;
        fpu_status_in = 4'd0;
        for (int k = 0; k < v.wait_cycles; k++) begin
            tick();
            chk("present_valid", {31'd0, rvalid0}, 32'd1);
            chk("present_result", result0, v.fpu_d);
            chk("present_status", {28'd0, status0}, {28'd0, v.fpu_s});
        end

        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        byte_valid   = 1'b0;
        chk("accept_valid", {31'd0, rvalid0}, 32'd0);
        chk("accept_byte_ready", {31'd0, byte_ready0}, 32'd1);
        chk("accept_busy", {31'd0, busy0}, 32'd0);
        chk_ops();
`ifdef FEEDER_OVERRUN_EN
        if (v.stray) m_ovr = 1'b1;
        chk("overrun_msb", {31'd0, ovr0}, {31'd0, m_ovr});
        chk("overrun_lsb", {31'd0, ovr1}, {31'd0, m_ovr});
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_a0 = 32'd0; m_b0 = 32'd0; m_a1 = 32'd0; m_b1 = 32'd0;
        m_ovr = 1'b0;

        vecs[0] = '{bytes: 64'h3E000000_40000000, gap: 1'b0, stray: 1'b0, wait_cycles: 0,
                    fpu_d: 32'h41000000, fpu_s: 4'b0001, exp_a: 32'h3E000000, exp_b: 32'h40000000};
        vecs[1] = '{bytes: 64'h0000003E_00000040, gap: 1'b1, stray: 1'b0, wait_cycles: 20,
                    fpu_d: 32'hC0800000, fpu_s: 4'b0010, exp_a: 32'h0000003E, exp_b: 32'h00000040};
        vecs[2] = '{bytes: 64'h12345678_9ABCDEF0, gap: 1'b1, stray: 1'b1, wait_cycles: 3,
                    fpu_d: 32'hDEADBEEF, fpu_s: 4'b1000, exp_a: 32'h12345678, exp_b: 32'h9ABCDEF0};
        vecs[3] = '{bytes: 64'h80000001_7FFFFFFE, gap: 1'b0, stray: 1'b0, wait_cycles: 1,
                    fpu_d: 32'h00000000, fpu_s: 4'b0100, exp_a: 32'h80000001, exp_b: 32'h7FFFFFFE};
        post_reset_vec = '{bytes: 64'hC0000000_3E000000, gap: 1'b0, stray: 1'b0, wait_cycles: 2,
                    fpu_d: 32'hBF000000, fpu_s: 4'b0001, exp_a: 32'hC0000000, exp_b: 32'h3E000000};

        reset         = 1'b0;
        byte_in       = 8'd0;
        byte_valid    = 1'b0;
        result_ready  = 1'b0;
        fpu_data_in   = 32'd0;
        fpu_status_in = 4'd0;
        repeat (2) @(posedge clock100KHz);
        #1;
        chk_ops();
        chk("reset_result", result0, 32'd0);
        chk("reset_status", {28'd0, status0}, 32'd0);
        chk("reset_valid", {31'd0, rvalid0}, 32'd0);
        chk("reset_busy", {31'd0, busy0}, 32'd0);
        chk("reset_byte_ready", {31'd0, byte_ready0}, 32'd1);
`ifdef FEEDER_OVERRUN_EN
        chk("reset_overrun", {31'd0, ovr0}, 32'd0);
`endif
        @(negedge clock100KHz);
        reset = 1'b1;
        tick();

        result_ready = 1'b1;
        repeat (2) tick();
        result_ready = 1'b0;
        chk("ready_ignored_valid", {31'd0, rvalid0}, 32'd0);
        chk("ready_ignored_byte_ready", {31'd0, byte_ready0}, 32'd1);

        for (int v = 0; v < 4; v++) run_vec(vecs[v]);

        byte_in    = 8'hFF;
        byte_valid = 1'b1;
        repeat (5) tick();
        byte_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        m_a0 = 32'd0; m_b0 = 32'd0; m_a1 = 32'd0; m_b1 = 32'd0;
        m_ovr = 1'b0;
        chk_ops();
        chk("midreset_byte_ready", {31'd0, byte_ready0}, 32'd1);
        chk("midreset_result", result0, 32'd0);
        chk("midreset_busy", {31'd0, busy0}, 32'd0);
`ifdef FEEDER_OVERRUN_EN
        chk("midreset_overrun", {31'd0, ovr0}, 32'd0);
`endif
        @(negedge clock100KHz);
        reset = 1'b1;
        tick();
        run_vec(post_reset_vec);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
